// File: rtl/button_conditioner.sv
// Fret-button conditioner: 2-flop synchronizer, per-channel debounce FSM, press/release pulses.
// Define BTN_AUTOREPEAT_EN to add held-button auto-repeat press pulses.
module button_conditioner #(
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 64,
  parameter int unsigned REPEAT_PERIOD   = 16
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               ncs,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic               any_press
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $fatal(1, "button_conditioner: DEBOUNCE_CYCLES must be >= 2, repeat timings >= 1");
  end

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StPressed,
    StReleaseWait
  } state_e;

  logic [NUM_BTN-1:0] sync1_q;
  logic [NUM_BTN-1:0] btn_sync;
  logic [NUM_BTN-1:0] press_hit;
  logic               any_q;

  // The synchronizer keeps running while disabled so re-enable sees current pin levels.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1_q  <= '0;
      btn_sync <= '0;
    end else begin
      sync1_q  <= btn_raw;
      btn_sync <= sync1_q;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            level_q;
    logic            press_q;
    logic            release_q;
    logic            rpt_hit;

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                     : REPEAT_PERIOD;
    localparam int unsigned RptW = (RptMax > 1) ? $clog2(RptMax) : 1;
    localparam logic [RptW-1:0] DelayLast  = RptW'(REPEAT_DELAY - 1);
    localparam logic [RptW-1:0] PeriodLast = RptW'(REPEAT_PERIOD - 1);

    logic [RptW-1:0] rpt_q;
    logic            repeating_q;

    assign rpt_hit = (state_q == StPressed) && btn_sync[i] &&
                     (rpt_q == (repeating_q ? PeriodLast : DelayLast));

    // Counts only while stably pressed; any other state restarts the initial delay.
    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        rpt_q       <= '0;
        repeating_q <= 1'b0;
      end else if (ncs) begin
        rpt_q       <= '0;
        repeating_q <= 1'b0;
      end else if ((state_q == StPressed) && btn_sync[i]) begin
        if (rpt_hit) begin
          rpt_q       <= '0;
          repeating_q <= 1'b1;
        end else begin
          rpt_q <= rpt_q + RptW'(1);
        end
      end else begin
        rpt_q       <= '0;
        repeating_q <= 1'b0;
      end
    end
`else
    assign rpt_hit = 1'b0;
`endif

    assign press_hit[i] = ((state_q == StPressWait) && btn_sync[i] && (cnt_q == CntMax)) ||
                          rpt_hit;

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        state_q   <= StIdle;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else if (ncs) begin
        state_q   <= StIdle;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= press_hit[i];
        release_q <= 1'b0;
        case (state_q)
          StIdle: begin
            if (btn_sync[i]) begin
              state_q <= StPressWait;
              cnt_q   <= '0;
            end
          end
          StPressWait: begin
            if (!btn_sync[i]) begin
              state_q <= StIdle;
              cnt_q   <= '0;
            end else if (cnt_q == CntMax) begin
              state_q <= StPressed;
              cnt_q   <= '0;
              level_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          StPressed: begin
            if (!btn_sync[i]) begin
              state_q <= StReleaseWait;
              cnt_q   <= '0;
            end
          end
          StReleaseWait: begin
            if (btn_sync[i]) begin
              state_q <= StPressed;
              cnt_q   <= '0;
            end else if (cnt_q == CntMax) begin
              state_q   <= StIdle;
              cnt_q     <= '0;
              level_q   <= 1'b0;
              release_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          default: begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end
        endcase
      end
    end

    assign btn_level[i]     = level_q;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = release_q;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      any_q <= 1'b0;
    end else begin
      any_q <= !ncs && (|press_hit);
    end
  end

  assign any_press = any_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios then random pin activity, all checked
// against a run-length debounce model.
module tb_button_conditioner;

  localparam int NB = 4;
  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 4;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic          clk;
  logic          nrst;
  logic          ncs;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] press_pulse;
  logic [NB-1:0] release_pulse;
  logic          any_press;

  button_conditioner #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk          (clk),
    .nrst         (nrst),
    .ncs          (ncs),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .any_press    (any_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Model: a channel flips once the synchronized pin has disagreed with the accepted
  // level for D+1 consecutive edges; m_hold counts stable held edges for auto-repeat.
  logic [NB-1:0] m_s1, m_s2, m_level, m_press, m_rel;
  logic          m_any;
  int            m_run  [NB];
  int            m_hold [NB];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_rel = '0; m_any = 1'b0;
    for (int c = 0; c < NB; c++) begin
      m_run[c]  = 0;
      m_hold[c] = 0;
    end
  endtask

  task automatic model_step();
    logic [NB-1:0] seen;
    if (!nrst) begin
      model_reset();
      return;
    end
    seen = m_s2;
    m_s2 = m_s1;
    m_s1 = btn_raw;
    m_press = '0;
    m_rel   = '0;
    for (int c = 0; c < NB; c++) begin
      if (ncs) begin
        m_level[c] = 1'b0;
        m_run[c]   = 0;
        m_hold[c]  = 0;
      end else if (seen[c] != m_level[c]) begin
        m_hold[c] = 0;
        m_run[c]++;
        if (m_run[c] == D + 1) begin
          m_run[c]   = 0;
          m_level[c] = seen[c];
          if (seen[c]) m_press[c] = 1'b1;
          else         m_rel[c]   = 1'b1;
        end
      end else if (m_run[c] != 0) begin
        m_run[c]  = 0;
        m_hold[c] = 0;
      end else if (m_level[c]) begin
        m_hold[c]++;
        if (AR && (m_hold[c] == RD || (m_hold[c] > RD && (m_hold[c] - RD) % RP == 0)))
          m_press[c] = 1'b1;
      end
    end
    m_any = |m_press;
  endtask

  task automatic compare_all();
    check("level", 32'(btn_level), 32'(m_level));
    check("press", 32'(press_pulse), 32'(m_press));
    check("release", 32'(release_pulse), 32'(m_rel));
    check("any_press", 32'(any_press), 32'(m_any));
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
    end
  endtask

  initial begin
    int rel_cnt;
    logic exp_p;

    nrst = 1'b0; ncs = 1'b0; btn_raw = '0;
    model_reset();
    step(2);
    check("rst_level", 32'(btn_level), 32'd0);
    check("rst_press", 32'(press_pulse), 32'd0);
    check("rst_release", 32'(release_pulse), 32'd0);
    check("rst_any", 32'(any_press), 32'd0);

    // Basic press on channel 0: accepted after edge D+3.
    nrst = 1'b1;
    btn_raw[0] = 1'b1;
    step(D + 2);
    check("p0_early_level", 32'(btn_level[0]), 32'd0);
    step(1);
    check("p0_level", 32'(btn_level[0]), 32'd1);
    check("p0_press", 32'(press_pulse[0]), 32'd1);
    check("p0_any", 32'(any_press), 32'd1);
    step(1);
    check("p0_press_gone", 32'(press_pulse[0]), 32'd0);

    // Bounce on channel 1 never settles long enough.
    rel_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      btn_raw[1] = ~btn_raw[1];
      step(1);
      rel_cnt += int'(press_pulse[1]) + int'(btn_level[1]);
    end
    btn_raw[1] = 1'b0;
    step(8);
    check("bounce_activity", 32'(rel_cnt), 32'd0);
    check("bounce_level", 32'(btn_level[1]), 32'd0);

    // Release on channel 2 with a one-cycle glitch.
    btn_raw[2] = 1'b1;
    step(D + 3);
    check("r2_pressed", 32'(btn_level[2]), 32'd1);
    btn_raw[2] = 1'b0;
    step(2);
    btn_raw[2] = 1'b1;
    step(1);
    btn_raw[2] = 1'b0;
    rel_cnt = 0;
    for (int i = 0; i < D + 2; i++) begin
      step(1);
      rel_cnt += int'(release_pulse[2]);
    end
    check("r2_still_high", 32'(btn_level[2]), 32'd1);
    step(1);
    check("r2_level_low", 32'(btn_level[2]), 32'd0);
    check("r2_release", 32'(release_pulse[2]), 32'd1);
    rel_cnt += int'(release_pulse[2]);
    for (int i = 0; i < 3; i++) begin
      step(1);
      rel_cnt += int'(release_pulse[2]);
    end
    check("r2_release_count", 32'(rel_cnt), 32'd1);

    // Simultaneous press on all channels.
    btn_raw = '0;
    step(12);
    btn_raw = 4'b1111;
    step(D + 2);
    check("sim_press_early", 32'(press_pulse), 32'd0);
    step(1);
    check("sim_press", 32'(press_pulse), 32'hf);
    check("sim_any", 32'(any_press), 32'd1);
    step(1);
    check("sim_press_end", 32'(press_pulse), 32'd0);
    check("sim_any_end", 32'(any_press), 32'd0);

    // Disable during PRESS_WAIT, then re-enable with the button held.
    btn_raw = '0;
    step(12);
    btn_raw[0] = 1'b1;
    step(4);
    ncs = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("dis_outputs", {btn_level, press_pulse, release_pulse, any_press}, 32'd0);
    end
    ncs = 1'b0;
    step(D);
    check("en_press_early", 32'(press_pulse[0]), 32'd0);
    step(1);
    check("en_press", 32'(press_pulse[0]), 32'd1);
    step(2);

    // Asynchronous reset while PRESSED clears the level without a clock edge.
    nrst = 1'b0;
    #1;
    check("arst_level", 32'(btn_level), 32'd0);
    check("arst_release", 32'(release_pulse), 32'd0);
    model_reset();
    step(2);

    // Held press after reset; with auto-repeat, pulses follow at +RD then every RP.
    nrst = 1'b1;
    for (int e = 1; e <= 24; e++) begin
      step(1);
      exp_p = (e == D + 3) || (AR && e >= D + 3 + RD && (e - D - 3 - RD) % RP == 0);
      check("hold_press", 32'(press_pulse[0]), 32'(exp_p));
    end
    btn_raw[0] = 1'b0;
    rel_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      check("hold_release_nopress", 32'(press_pulse[0]), 32'd0);
      rel_cnt += int'(release_pulse[0]);
    end
    check("hold_release_count", 32'(rel_cnt), 32'd1);

    // Random pin activity with occasional disable.
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < NB; c++)
        if ($urandom_range(0, 5) == 0) btn_raw[c] = ~btn_raw[c];
      ncs = ($urandom_range(0, 49) == 0);
      step(1);
    end
    ncs = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
